// File: rtl/inst_fetch_unit.sv
// ---------------------------------------------------------------------------
// inst_fetch_unit
//   Fetch stage of the multi-cycle core. Drives the instruction memory (IM)
//   address and strobes, holds IM_read for IM_LAT cycles, latches the returned
//   word into ir and offers it to decode. Branch/jump redirects restart the
//   fetch at a new address; fetching stops (halt) once the last IM word
//   (address all-ones) has been consumed.
//
// Parameters
//   DataSize  instruction width
//   MemSize   IM address width (word addressed)
//   IM_LAT    cycles IM_read is held before the IM output is valid (>=1)
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-low reset
//   start        in   1-cycle pulse: begin fetching at PC 0
//   instruction  in   IM data out
//   PC           out  IM address (always the current fetch pointer)
//   IM_read      out  IM fetch enable
//   IM_write     out  IM write enable, tied to 0
//   IM_enable    out  IM chip enable
//   ir           out  latched instruction
//   ir_pc        out  address ir was fetched from
//   ir_valid     out  ir holds an unconsumed instruction
//   ir_ready     in   decode accepts ir this cycle
//   redirect     in   take redirect_pc as next fetch address
//   redirect_pc  in   branch/jump target
//   halt         out  fetch stopped after the last IM word
//   state_o      out  FSM state, for debug/observability
//
// Handshake: ir/ir_pc are offered while ir_valid=1 and a transfer happens on
// every rising edge where ir_valid & ir_ready. Once raised, ir_valid stays high
// and ir/ir_pc stay constant until a transfer or a redirect.
// ---------------------------------------------------------------------------
module inst_fetch_unit #(
  parameter int DataSize = 32,
  parameter int MemSize  = 10,
  parameter int IM_LAT   = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [DataSize-1:0] instruction,
  output logic [MemSize-1:0]  PC,
  output logic                IM_read,
  output logic                IM_write,
  output logic                IM_enable,
  output logic [DataSize-1:0] ir,
  output logic [MemSize-1:0]  ir_pc,
  output logic                ir_valid,
  input  logic                ir_ready,
  input  logic                redirect,
  input  logic [MemSize-1:0]  redirect_pc,
  output logic                halt,
  output logic [2:0]          state_o
);

  localparam int CntW = (IM_LAT > 1) ? $clog2(IM_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_CAPTURE = 3'd2,
    S_HOLD    = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [MemSize-1:0]  pc_q, pc_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [DataSize-1:0] ir_q, ir_d;
  logic [MemSize-1:0]  ir_pc_q, ir_pc_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      ir_q    <= '0;
      ir_pc_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      ir_q    <= ir_d;
      ir_pc_q <= ir_pc_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    ir_d    = ir_q;
    ir_pc_d = ir_pc_q;
    valid_d = valid_q;
    last_d  = last_q;

    // A redirect wins over every other transition. A transfer on the same
    // edge is implicitly completed: ir_valid drops either way. ir/ir_pc are
    // left untouched so an in-flight CAPTURE word is simply discarded.
    if (redirect && (state_q != S_IDLE)) begin
      pc_d    = redirect_pc;
      valid_d = 1'b0;
      cnt_d   = '0;
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            pc_d    = '0;
            cnt_d   = '0;
            state_d = S_FETCH;
          end
        end
        S_FETCH: begin
          if (cnt_q == CntW'(IM_LAT - 1)) begin
            cnt_d   = '0;
            state_d = S_CAPTURE;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
        S_CAPTURE: begin
          ir_d    = instruction;
          ir_pc_d = pc_q;
          valid_d = 1'b1;
          last_d  = (pc_q == '1);
          pc_d    = pc_q + MemSize'(1);   // wraps to 0 after the last word
          state_d = S_HOLD;
        end
        S_HOLD: begin
          if (valid_q && ir_ready) begin
            valid_d = 1'b0;
            cnt_d   = '0;
            state_d = last_q ? S_DONE : S_FETCH;
          end
        end
        S_DONE: begin
          valid_d = 1'b0;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign PC        = pc_q;
  assign IM_read   = (state_q == S_FETCH);
  assign IM_enable = (state_q == S_FETCH) || (state_q == S_CAPTURE);
  assign IM_write  = 1'b0;
  assign ir        = ir_q;
  assign ir_pc     = ir_pc_q;
  assign ir_valid  = valid_q;
  assign halt      = (state_q == S_DONE);
  assign state_o   = state_q;

endmodule
